// File: rtl/mem_readback_pkg.sv
// Shared types and constants for the memory readback engine.
// Optional checksum feature is controlled by MEM_READBACK_CKSUM_EN.
package mem_readback_pkg;

    // Default geometry of the 128x8 instruction/data memory.
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    // Number of addressable bytes.
    localparam int RB_MEM_DEPTH = 1 << ADDR_W;

    // Readback sequencer states. CKS is only reachable with the checksum
    // feature built in.
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAP,
        SEND,
        CKS,
        FIN
    } rb_state_t;

endpackage : mem_readback_pkg

// File: rtl/mem_readback_if.sv
// Bus bundle between the readback engine, the memory read port and the
// pad-side consumer. The engine uses the slave view and its environment
// uses the master view.
interface mem_readback_if #(
    parameter int ADDR_W = mem_readback_pkg::ADDR_W,
    parameter int DATA_W = mem_readback_pkg::DATA_W
);

    // Command side
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;

    // Memory read port
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    // Pad-side stream
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // Status
    logic              busy;
    logic              done;

    modport slave (
        input  start, base_addr, length, mem_rdata, out_ready,
        output mem_re, mem_addr, out_data, out_valid, busy, done
    );

    modport master (
        output start, base_addr, length, mem_rdata, out_ready,
        input  mem_re, mem_addr, out_data, out_valid, busy, done
    );

endinterface : mem_readback_if

// File: rtl/readback_cksum.sv
// Running 8-bit (mod 2^DATA_W) sum of the bytes streamed by the readback
// engine. Only built when MEM_READBACK_CKSUM_EN is defined.
`ifdef MEM_READBACK_CKSUM_EN
module readback_cksum #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] r_sum;

    // Clear at the start of a dump, then add each accepted byte.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_sum <= '0;
        end else if (en) begin
            r_sum <= r_sum + din;
        end
    end

    assign sum = r_sum;

endmodule : readback_cksum
`endif

// File: rtl/mem_readback.sv
// Readback engine: dumps a range of the instruction/data memory through
// its synchronous read port onto a valid/ready byte stream.
// Define MEM_READBACK_CKSUM_EN to append a mod-256 checksum byte.
module mem_readback #(
    parameter int ADDR_W = mem_readback_pkg::ADDR_W,
    parameter int DATA_W = mem_readback_pkg::DATA_W
) (
    input logic            clk,
    input logic            rst,
    mem_readback_if.slave  bus
);

    import mem_readback_pkg::*;

    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    rb_state_t         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_mem_re;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_done;

    logic [ADDR_W-1:0] w_addr_next;
    logic              w_handshake;

    // Address increment wraps naturally at the top of the memory.
    assign w_addr_next = r_addr + 1'b1;
    assign w_handshake = r_out_valid && bus.out_ready;

`ifdef MEM_READBACK_CKSUM_EN
    logic              w_cksum_clr;
    logic              w_cksum_en;
    logic [DATA_W-1:0] w_cksum;
    logic [DATA_W-1:0] w_cksum_final;

    assign w_cksum_clr = (r_state == IDLE) && bus.start;
    assign w_cksum_en  = (r_state == SEND) && w_handshake;
    // The accumulator updates on the same edge as the last handoff, so the
    // byte being accepted is folded in here to present the final sum at once.
    assign w_cksum_final = w_cksum + r_out_data;

    readback_cksum #(
        .DATA_W (DATA_W)
    ) u_cksum (
        .clk (clk),
        .rst (rst),
        .clr (w_cksum_clr),
        .en  (w_cksum_en),
        .din (r_out_data),
        .sum (w_cksum)
    );
`endif

    // Sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_mem_re    <= 1'b0;
            r_mem_addr  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // NOTE: pulse outputs get a default here; a later non-blocking
            // assignment in the case below overrides it for this edge.
            r_mem_re <= 1'b0;
            r_done   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if (bus.length != '0) begin
                            r_addr      <= bus.base_addr;
                            r_remaining <= bus.length;
                            r_mem_re    <= 1'b1;
                            r_mem_addr  <= bus.base_addr;
                            r_state     <= REQ;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end
                    end
                end

                REQ: begin
                    r_state <= CAP;
                end

                CAP: begin
                    r_out_data  <= bus.mem_rdata;
                    r_out_valid <= 1'b1;
                    r_state     <= SEND;
                end

                SEND: begin
                    if (bus.out_ready) begin
                        r_addr      <= w_addr_next;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining != LEN_ONE) begin
                            r_out_valid <= 1'b0;
                            r_mem_re    <= 1'b1;
                            r_mem_addr  <= w_addr_next;
                            r_state     <= REQ;
                        end else begin
`ifdef MEM_READBACK_CKSUM_EN
                            r_out_data <= w_cksum_final;
                            r_state    <= CKS;
`else
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= FIN;
`endif
                        end
                    end
                end

                CKS: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= FIN;
                    end
                end

                FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_re    = r_mem_re;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule : mem_readback

// File: tb/tb_mem_readback.sv
// Directed bench for mem_readback with a behavioural synchronous memory.
// Checksum scenario is included when MEM_READBACK_CKSUM_EN is defined.
module tb_mem_readback;

    import mem_readback_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [DATA_W-1:0] mem [RB_MEM_DEPTH];
    logic [DATA_W-1:0] exp_data [$];
    logic [ADDR_W-1:0] exp_addr [$];

    mem_readback_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_readback #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory model: data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one dump and compare every cycle 1..ncyc against hand-derived
    // masks (bit c = cycle c). Addresses and accepted bytes are popped from
    // exp_addr / exp_data in order.
    task automatic run_dump(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len,
                            input logic [31:0] re_m, input logic [31:0] val_m,
                            input logic [31:0] rdy_m, input int done_cyc,
                            input int ncyc, input string name);
        logic              prev_hold;
        logic [DATA_W-1:0] prev_data;
        prev_hold = 1'b0;
        prev_data = '0;
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.length    = len;
        bus.out_ready = rdy_m[0];
        for (int c = 1; c <= ncyc; c++) begin
            cyc();
            bus.start     = 1'b0;
            bus.out_ready = rdy_m[c];
            chk({name, "_re"},    32'(bus.mem_re),    32'(re_m[c]));
            chk({name, "_valid"}, 32'(bus.out_valid), 32'(val_m[c]));
            chk({name, "_done"},  32'(bus.done),      32'(c == done_cyc));
            chk({name, "_busy"},  32'(bus.busy),      32'(c <= done_cyc));
            if (bus.mem_re) begin
                if (exp_addr.size() == 0) chk({name, "_extra_re"}, 1, 0);
                else chk({name, "_addr"}, 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
            end
            if (prev_hold) chk({name, "_stable"}, 32'(bus.out_data), 32'(prev_data));
            if (bus.out_valid && rdy_m[c]) begin
                if (exp_data.size() == 0) chk({name, "_extra_byte"}, 1, 0);
                else chk({name, "_data"}, 32'(bus.out_data), 32'(exp_data.pop_front()));
            end
            prev_hold = bus.out_valid && !rdy_m[c];
            prev_data = bus.out_data;
        end
        chk({name, "_addr_left"}, 32'(exp_addr.size()), 0);
        chk({name, "_data_left"}, 32'(exp_data.size()), 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < RB_MEM_DEPTH; i++) mem[i] = '0;
        mem[7'h10] = 8'h11; mem[7'h11] = 8'h22; mem[7'h12] = 8'h33;
        mem[7'h7E] = 8'hA1; mem[7'h7F] = 8'hA2; mem[7'h00] = 8'hA3; mem[7'h01] = 8'hA4;
        mem[7'h20] = 8'hF0; mem[7'h21] = 8'h20;

        // Reset held together with a start request: reset must win.
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.base_addr = 7'h10;
        bus.length    = 8'd3;
        bus.out_ready = 1'b0;
        bus.mem_rdata = '0;
        cyc();
        cyc();
        chk("rst_re",    32'(bus.mem_re),    0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_busy",  32'(bus.busy),      0);
        chk("rst_done",  32'(bus.done),      0);
        chk("rst_data",  32'(bus.out_data),  0);
        chk("rst_addr",  32'(bus.mem_addr),  0);
        bus.start = 1'b0;
        rst       = 1'b0;
        cyc();
        chk("idle_busy", 32'(bus.busy), 0);

        // Basic dump: bytes on cycles 3, 6, 9; done on 10.
        exp_addr = '{7'h10, 7'h11, 7'h12};
        exp_data = '{8'h11, 8'h22, 8'h33};
        run_dump(7'h10, 8'd3, 32'h0000_0092, 32'h0000_0248, 32'hFFFF_FFFF, 10, 12, "basic");

        // Backpressure: ready low in cycles 6..10 while byte 2 is offered.
        exp_addr = '{7'h10, 7'h11, 7'h12};
        exp_data = '{8'h11, 8'h22, 8'h33};
        run_dump(7'h10, 8'd3, 32'h0000_1012, 32'h0000_4FC8, 32'hFFFF_F83F, 15, 17, "bp");

        // Wrap-around past the top address.
        exp_addr = '{7'h7E, 7'h7F, 7'h00, 7'h01};
        exp_data = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        run_dump(7'h7E, 8'd4, 32'h0000_0492, 32'h0000_1248, 32'hFFFF_FFFF, 13, 15, "wrap");

        // Zero length: no memory access, done in cycle 1.
        run_dump(7'h10, 8'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1, 3, "zero");

        // Reset during the second SEND (cycle 6).
        bus.start     = 1'b1;
        bus.base_addr = 7'h10;
        bus.length    = 8'd3;
        bus.out_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            bus.start = 1'b0;
        end
        chk("mid_valid_before", 32'(bus.out_valid), 1);
        chk("mid_data_before",  32'(bus.out_data),  32'h22);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        chk("mid_valid", 32'(bus.out_valid), 0);
        chk("mid_busy",  32'(bus.busy),      0);
        chk("mid_done",  32'(bus.done),      0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("mid_no_done", 32'(bus.done), 0);
            chk("mid_idle_re", 32'(bus.mem_re), 0);
        end

        // A fresh start after the abort behaves normally.
        exp_addr = '{7'h10, 7'h11, 7'h12};
        exp_data = '{8'h11, 8'h22, 8'h33};
        run_dump(7'h10, 8'd3, 32'h0000_0092, 32'h0000_0248, 32'hFFFF_FFFF, 10, 12, "restart");

`ifdef MEM_READBACK_CKSUM_EN
        // 0xF0 + 0x20 = 0x110 -> checksum 0x10 presented in cycle 7.
        exp_addr = '{7'h20, 7'h21};
        exp_data = '{8'hF0, 8'h20, 8'h10};
        run_dump(7'h20, 8'd2, 32'h0000_0012, 32'h0000_00C8, 32'hFFFF_FFFF, 8, 10, "cksum");
`else
        exp_addr = '{7'h20, 7'h21};
        exp_data = '{8'hF0, 8'h20};
        run_dump(7'h20, 8'd2, 32'h0000_0012, 32'h0000_0048, 32'hFFFF_FFFF, 7, 9, "pair");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_readback

// File: doc/mem_readback.md
# mem_readback

Readback engine for the CPU's 128×8 instruction/data memory, the reverse path of the pin-driven instruction loader. On a start pulse it reads `length` consecutive bytes beginning at `base_addr` through the memory's synchronous read port. It streams each byte to the pad-side output register over a valid/ready handshake, so a host can verify a program it has loaded. It sits beside the CPU core in the top-level wrapper and shares the memory's read port when the CPU is held idle.

## Interface

**Parameters**
- `ADDR_W`, 7: memory address width; address space is 2^ADDR_W bytes.
- `DATA_W`, 8: memory word width.

**Ports** (clock and reset first)
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to begin a dump; sampled only in IDLE.
- `base_addr` input ADDR_W: first address read; sampled together with `start`.
- `length` input ADDR_W+1: byte count, 0..128; sampled together with `start`.
- `mem_re` output 1: memory read enable.
- `mem_addr` output ADDR_W: memory read address.
- `mem_rdata` input DATA_W: read data, valid the cycle after `mem_re`.
- `out_data` output DATA_W: streamed byte.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: the consumer accepts the byte this cycle.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when the dump completes.

## Operation

- **FSM states:** IDLE, REQ, CAP, SEND, FIN (plus CKS with the feature enabled).
- **IDLE:**
  - `start`=1 and `length`≠0: latch `addr`←`base_addr` and `remaining`←`length`, then go to REQ.
  - `start`=1 and `length`=0: go to FIN with no memory access.
- **REQ:** assert `mem_re`=1 with `mem_addr`=`addr`, then go to CAP.
- **CAP:** register `mem_rdata` into `out_data`, then go to SEND.
- **SEND:**
  - Hold `out_valid`=1 with `out_data` stable until `out_ready`=1.
  - On the handshake: `addr`←`addr`+1 (modulo 2^ADDR_W, wraps 127→0) and `remaining`←`remaining`−1.
  - Next state is REQ if `remaining`≠1, otherwise FIN (or CKS when the feature is enabled).
- **FIN:** assert `done`=1 for one cycle, then go to IDLE.
- `start` is ignored while `busy`=1. There is no abort other than `rst`.
- `mem_re` is high only in REQ. `mem_addr` holds its last value otherwise.
- `out_valid` never drops without a handshake, except on `rst`.

## Timing

- **Reset values:**
  - State is IDLE.
  - `mem_re`, `out_valid`, `busy`, `done` are 0.
  - `out_data`, `mem_addr`, the internal address and the counter are 0.
- **Latency:**
  - `start` is sampled at edge 0.
  - `mem_re` is high in cycle 1.
  - `out_valid` first rises in cycle 3.
- **Throughput:** with `out_ready` tied high, one byte every 3 cycles.
- **`done`:** pulses in the cycle after the final handshake.
  - For `length`=0 it pulses in cycle 1.
- **Reset mid-operation:** `rst` in any state returns to IDLE on the next edge, with `out_valid` low and no `done` pulse.
- **Simultaneous events:** `rst` together with `start`: `rst` wins.

## Configuration

- Macro: `MEM_READBACK_CKSUM_EN`.
- **Defined:**
  - An 8-bit sum (mod 256) accumulates every byte handed off in SEND and clears on `start`.
  - After the last data byte, state CKS presents the sum with `out_valid`=1, using the same handshake rule.
  - FIN follows the checksum handshake.
  - `length`=0 sends no checksum.
- **Undefined:** no CKS state and no accumulator; SEND goes straight to FIN.

## Structure

- **Package `mem_readback_pkg`:**
  - `ADDR_W` and `DATA_W` defaults.
  - The state enum `rb_state_t` (IDLE, REQ, CAP, SEND, CKS, FIN).
  - Constant `RB_MEM_DEPTH` = 2^ADDR_W.
- **Sub-module `readback_cksum`:**
  - The checksum accumulator, with `clr`, `en`, `din` and `sum` ports.
  - Instantiated only under `MEM_READBACK_CKSUM_EN`.
- Everything else is a single FSM module.

## Test plan

- **Basic dump:** memory preloaded with bytes {0x11,0x22,0x33} at 0x10..0x12; `start` with `base_addr`=0x10, `length`=3, `out_ready`=1 -> `out_data` 0x11, 0x22, 0x33 on cycles 3, 6, 9; `done` on cycle 10.
- **Backpressure:** same stimulus, `out_ready` held low for 5 cycles on byte 2 -> 0x22 stable with `out_valid` high throughout; no extra `mem_re`; order preserved.
- **Wrap-around:** `base_addr`=0x7E, `length`=4 -> `mem_addr` sequence 0x7E, 0x7F, 0x00, 0x01.
- **Zero length:** `length`=0 -> no `mem_re`, no `out_valid`, `done` pulses in cycle 1.
- **Reset mid-dump:** `rst` asserted during the second SEND -> next cycle IDLE, `out_valid`=0, `busy`=0, no `done`; a new `start` works normally.
- **Checksum (`MEM_READBACK_CKSUM_EN`):** bytes {0xF0,0x20} -> stream is 0xF0, 0x20, then 0x10; `done` follows the checksum handshake.
